// File: rtl/frame_buf_arbiter.sv
// Shares one single-port frame-buffer BRAM between the camera writer and the display reader.
// Define FB_DOUBLE_BUFFER_EN for ping-pong banks selected by an extra address MSB.
module frame_buf_arbiter #(
  parameter int unsigned ROLLOVER    = 76800,
  parameter int unsigned WR_RST_ADDR = 0,
  parameter int unsigned RD_RST_ADDR = 0,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 2,
  localparam int unsigned OFF_W      = $clog2(ROLLOVER),
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned ADDR_W     = OFF_W + 1
`else
  localparam int unsigned ADDR_W     = OFF_W
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_valid_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              wr_frame_start_in,
  output logic              wr_ready_out,
  input  logic              rd_req_in,
  input  logic              rd_frame_start_in,
  output logic              rd_ack_out,
  output logic              rd_data_valid_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_din_out,
  input  logic [DATA_W-1:0] mem_dout_in
);

  typedef logic [OFF_W-1:0] off_t;

  localparam off_t WrRst = off_t'(WR_RST_ADDR);
  localparam off_t RdRst = off_t'(RD_RST_ADDR);

  function automatic off_t off_inc(input off_t a);
    return (a == off_t'(ROLLOVER - 1)) ? '0 : a + off_t'(1);
  endfunction

  logic [DATA_W:0]    fifo_q [2];
  logic               fifo_wptr_q, fifo_rptr_q;
  logic [1:0]         fifo_cnt_q;
  logic               fifo_full, fifo_empty, push, pop;
  logic               head_sof;
  logic [DATA_W-1:0]  head_data;
  logic               last_rd_q;
  off_t               wr_off_q, rd_off_q;
  logic               rd_sof_q, rd_sof_now;
  logic [MEM_LATENCY:0] vpipe_q;
  logic               grant_wr, grant_rd;
  off_t               wr_addr, rd_addr;
  logic [ADDR_W-1:0]  wr_full_addr, rd_full_addr;
`ifdef FB_DOUBLE_BUFFER_EN
  logic               wr_bank_q, rd_bank_q;
`endif

  assign fifo_full    = (fifo_cnt_q == 2'd2);
  assign fifo_empty   = (fifo_cnt_q == 2'd0);
  assign wr_ready_out = !fifo_full;
  assign push         = wr_valid_in && !fifo_full;
  assign pop          = grant_wr;
  assign {head_sof, head_data} = fifo_q[fifo_rptr_q];

  // Write wins when the reader is idle, the buffer is full, or the reader had the last turn.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (rst_in) begin
      if (!fifo_empty && (!rd_req_in || fifo_full || last_rd_q)) begin
        grant_wr = 1'b1;
      end else if (rd_req_in) begin
        grant_rd = 1'b1;
      end
    end
  end

  assign rd_sof_now = rd_sof_q || rd_frame_start_in;
  assign wr_addr    = head_sof ? WrRst : wr_off_q;
  assign rd_addr    = rd_sof_now ? RdRst : rd_off_q;

`ifdef FB_DOUBLE_BUFFER_EN
  // A frame-start write moves to the other bank; a frame-start read follows the bank just written.
  assign wr_full_addr = {(head_sof ? !wr_bank_q : wr_bank_q), wr_addr};
  assign rd_full_addr = {(rd_sof_now ? !wr_bank_q : rd_bank_q), rd_addr};
`else
  assign wr_full_addr = wr_addr;
  assign rd_full_addr = rd_addr;
`endif

  assign rd_ack_out        = grant_rd;
  assign rd_data_valid_out = vpipe_q[MEM_LATENCY];
  assign rd_data_out       = mem_dout_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      fifo_wptr_q  <= 1'b0;
      fifo_rptr_q  <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      last_rd_q    <= 1'b1;
      wr_off_q     <= WrRst;
      rd_off_q     <= RdRst;
      rd_sof_q     <= 1'b0;
      vpipe_q      <= '0;
      mem_we_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_din_out  <= '0;
`ifdef FB_DOUBLE_BUFFER_EN
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
`endif
    end else begin
      if (push) begin
        fifo_q[fifo_wptr_q] <= {wr_frame_start_in, wr_data_in};
        fifo_wptr_q         <= !fifo_wptr_q;
      end
      if (pop) begin
        fifo_rptr_q <= !fifo_rptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      vpipe_q    <= {vpipe_q[MEM_LATENCY-1:0], grant_rd};
      rd_sof_q   <= rd_sof_now && !grant_rd;
      mem_we_out <= grant_wr;
      if (grant_wr) begin
        last_rd_q    <= 1'b0;
        wr_off_q     <= off_inc(wr_addr);
        mem_addr_out <= wr_full_addr;
        mem_din_out  <= head_data;
`ifdef FB_DOUBLE_BUFFER_EN
        if (head_sof) wr_bank_q <= !wr_bank_q;
`endif
      end else if (grant_rd) begin
        last_rd_q    <= 1'b1;
        rd_off_q     <= off_inc(rd_addr);
        mem_addr_out <= rd_full_addr;
`ifdef FB_DOUBLE_BUFFER_EN
        if (rd_sof_now) rd_bank_q <= !wr_bank_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Scoreboard bench for frame_buf_arbiter: expected BRAM port traffic and read data are queued
// as stimulus is driven and consumed by a port monitor.
`timescale 1ns/1ps
module tb_frame_buf_arbiter;
  localparam int unsigned ROLL = 11;
  localparam int unsigned DW   = 16;
  localparam int unsigned LAT  = 2;
  localparam int unsigned OW   = $clog2(ROLL);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned AW   = OW + 1;
`else
  localparam int unsigned AW   = OW;
`endif
  localparam int unsigned MEM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0, wr_sof = 1'b0, rd_req = 1'b0, rd_sof = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ack, rd_dv, mem_we;
  logic [DW-1:0] rd_data, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  frame_buf_arbiter #(
    .ROLLOVER(ROLL), .WR_RST_ADDR(0), .RD_RST_ADDR(0), .DATA_W(DW), .MEM_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_in(rst_n),
    .wr_valid_in(wr_valid), .wr_data_in(wr_data), .wr_frame_start_in(wr_sof),
    .wr_ready_out(wr_ready),
    .rd_req_in(rd_req), .rd_frame_start_in(rd_sof), .rd_ack_out(rd_ack),
    .rd_data_valid_out(rd_dv), .rd_data_out(rd_data),
    .mem_addr_out(mem_addr), .mem_we_out(mem_we), .mem_din_out(mem_din),
    .mem_dout_in(mem_dout)
  );

  // BRAM model, read latency LAT from address on the port
  logic [DW-1:0] mem [MEM_N];
  logic [DW-1:0] shadow [MEM_N];
  logic [DW-1:0] r1, r2;
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < int'(MEM_N); i++) mem[i] <= DW'(i * 37 + 5);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    r1 <= mem[mem_addr];
    r2 <= r1;
  end
  assign mem_dout = r2;

  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0]    raq[$];
  logic [DW-1:0]    rq[$];
  int n_chk = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic ack_prev = 1'b0;
  logic [AW+DW-1:0] mon_w;
  logic [AW-1:0]    mon_a;
  logic [DW-1:0]    mon_d;

  logic [OW-1:0] m_wr_off, m_rd_off;
  logic          m_wr_bank, m_rd_bank, m_rd_sof;

  // Port monitor: consumes the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      ack_prev = 1'b0;
    end else begin
      if (mem_we) begin
        n_chk++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL wr_port: unexpected write addr=%0h din=%0h", mem_addr, mem_din);
        end else begin
          mon_w = wq.pop_front();
          if ({mem_addr, mem_din} !== mon_w) begin
            n_fail++;
            $display("FAIL wr_port: got addr=%0h din=%0h expected addr=%0h din=%0h",
                     mem_addr, mem_din, mon_w[AW+DW-1:DW], mon_w[DW-1:0]);
          end
        end
      end else if (ack_prev) begin
        n_chk++;
        if (raq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_port: unexpected read addr=%0h", mem_addr);
        end else begin
          mon_a = raq.pop_front();
          if (mem_addr !== mon_a) begin
            n_fail++;
            $display("FAIL rd_port: got addr=%0h expected %0h", mem_addr, mon_a);
          end
        end
      end
      if (rd_dv) begin
        n_chk++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: unexpected valid data=%0h", rd_data);
        end else begin
          mon_d = rq.pop_front();
          if (rd_data !== mon_d) begin
            n_fail++;
            $display("FAIL rd_data: got %0h expected %0h", rd_data, mon_d);
          end
        end
      end
      ack_prev = rd_ack;
    end
  end

  task automatic model_wr(input logic sof, input logic [DW-1:0] d);
    logic [OW-1:0] o;
    logic [AW-1:0] a;
    o = sof ? OW'(0) : m_wr_off;
`ifdef FB_DOUBLE_BUFFER_EN
    if (sof) m_wr_bank = ~m_wr_bank;
    a = {m_wr_bank, o};
`else
    a = o;
`endif
    m_wr_off = (o == OW'(ROLL - 1)) ? '0 : o + 1'b1;
    shadow[a] = d;
    wq.push_back({a, d});
  endtask

  task automatic model_rd();
    logic [OW-1:0] o;
    logic [AW-1:0] a;
    o = m_rd_sof ? OW'(0) : m_rd_off;
`ifdef FB_DOUBLE_BUFFER_EN
    if (m_rd_sof) m_rd_bank = ~m_wr_bank;
    a = {m_rd_bank, o};
`else
    a = o;
`endif
    m_rd_sof = 1'b0;
    m_rd_off = (o == OW'(ROLL - 1)) ? '0 : o + 1'b1;
    raq.push_back(a);
    rq.push_back(shadow[a]);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    wr_valid = 1'b0; wr_sof = 1'b0; rd_req = 1'b0; rd_sof = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wq.delete(); raq.delete(); rq.delete();
    m_wr_off = '0; m_rd_off = '0; m_wr_bank = 1'b0; m_rd_bank = 1'b1; m_rd_sof = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    rd_req = 1'b1; wr_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b expected 0", mem_we); end
    n_chk++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", mem_addr); end
    n_chk++; if (mem_din !== '0) begin n_fail++; $display("FAIL rst_din: got %0h expected 0", mem_din); end
    n_chk++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %0b expected 0", rd_ack); end
    n_chk++; if (rd_dv !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %0b expected 0", rd_dv); end
    rd_req = 1'b0; wr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b expected 1", wr_ready); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_idle_we: got %0b expected 0", mem_we); end
  endtask

  task automatic check_drained(input string name);
    n_chk++;
    if (wq.size() != 0 || raq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL %s: pending wr=%0d rd_addr=%0d rd_data=%0d expected 0 0 0",
               name, wq.size(), raq.size(), rq.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = DW'(16'h1000 + i);
      model_wr(1'b0, wr_data);
      @(negedge clk);
      n_chk++;
      if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %0b expected 1", i, wr_ready); end
    end
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_drained("wrap_drain");
  endtask

  task automatic test_arbitration();
    int k;
    logic exp_ready, exp_ack;
    do_reset();
    k = 0;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      exp_ready = (c < 3) || (c % 2 == 0);
      exp_ack   = (c >= 2) && (c % 2 == 0);
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = DW'(16'h2000 + k);
      rd_req = (c >= 1);
      if (exp_ready) begin model_wr(1'b0, wr_data); k++; end
      if (exp_ack) model_rd();
      @(negedge clk);
      n_chk++;
      if (wr_ready !== exp_ready) begin
        n_fail++; $display("FAIL arb_ready[%0d]: got %0b expected %0b", c, wr_ready, exp_ready);
      end
      n_chk++;
      if (rd_ack !== exp_ack) begin
        n_fail++; $display("FAIL arb_ack[%0d]: got %0b expected %0b", c, rd_ack, exp_ack);
      end
    end
    @(posedge clk); #1 wr_valid = 1'b0; rd_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_drained("arb_drain");
  endtask

  task automatic test_write_sof();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_sof = (i == 7); wr_data = DW'(16'h3000 + i);
      model_wr(wr_sof, wr_data);
    end
    @(posedge clk); #1 wr_valid = 1'b0; wr_sof = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_drained("wsof_drain");
  endtask

  task automatic test_read_sof();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 rd_req = 1'b1;
      model_rd();
      @(negedge clk);
      n_chk++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL rd_b2b_ack[%0d]: got %0b expected 1", i, rd_ack); end
    end
    @(posedge clk); #1 rd_req = 1'b0; rd_sof = 1'b1; m_rd_sof = 1'b1;
    @(negedge clk);
    n_chk++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL rsof_pulse_ack: got %0b expected 0", rd_ack); end
    @(posedge clk); #1 rd_sof = 1'b0;
    repeat (5) @(posedge clk);
    #1 rd_req = 1'b1;
    model_rd();
    @(negedge clk);
    n_chk++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL rsof_ack: got %0b expected 1", rd_ack); end
    @(posedge clk); #1 rd_req = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      if (t > 1) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (rd_dv !== (t == 3)) begin
        n_fail++; $display("FAIL rd_latency[T+%0d]: got %0b expected %0b", t, rd_dv, (t == 3));
      end
    end
    @(posedge clk); #1 rd_req = 1'b1;
    model_rd();
    @(posedge clk); #1 rd_req = 1'b1; rd_sof = 1'b1; m_rd_sof = 1'b1;
    model_rd();
    @(negedge clk);
    n_chk++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL rsof_same_ack: got %0b expected 1", rd_ack); end
    @(posedge clk); #1 rd_req = 1'b0; rd_sof = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_drained("rsof_drain");
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_sof = 1'b0; wr_data = DW'(16'h4000 + c); rd_req = 1'b1;
      model_wr(1'b0, wr_data);
      if (c != 1) model_rd();
    end
    @(posedge clk); #1;
    mon_en = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; rst_n = 1'b0;
    #1;
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mrst_we: got %0b expected 0", mem_we); end
    n_chk++; if (mem_addr !== '0) begin n_fail++; $display("FAIL mrst_addr: got %0h expected 0", mem_addr); end
    n_chk++; if (mem_din !== '0) begin n_fail++; $display("FAIL mrst_din: got %0h expected 0", mem_din); end
    n_chk++; if (rd_dv !== 1'b0) begin n_fail++; $display("FAIL mrst_dv: got %0b expected 0", rd_dv); end
    @(posedge clk); #1 rst_n = 1'b1;
    wq.delete(); raq.delete(); rq.delete();
    m_wr_off = '0; m_rd_off = '0; m_wr_bank = 1'b0; m_rd_bank = 1'b1; m_rd_sof = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mrst_empty_we[%0d]: got %0b expected 0", i, mem_we); end
      n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready[%0d]: got %0b expected 1", i, wr_ready); end
    end
    @(posedge clk); #1 wr_valid = 1'b1; wr_data = 16'h4abc;
    model_wr(1'b0, wr_data);
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_drained("mrst_drain");
  endtask

`ifdef FB_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_sof = (i == 0); wr_data = DW'(16'h5000 + i);
      model_wr(wr_sof, wr_data);
    end
    @(posedge clk); #1 wr_valid = 1'b0; wr_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1 rd_req = 1'b1; rd_sof = 1'b1; m_rd_sof = 1'b1;
    model_rd();
    @(negedge clk);
    n_chk++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL db_ack: got %0b expected 1", rd_ack); end
    @(posedge clk); #1 rd_sof = 1'b0;
    model_rd();
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_drained("db_drain");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(MEM_N); i++) shadow[i] = DW'(i * 37 + 5);
    test_reset();
    test_wrap();
    test_arbitration();
    test_write_sof();
    test_read_sof();
    test_mid_reset();
`ifdef FB_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
